// File: rtl/lisnoc_mp_simple_arb_if.sv
// Handshake bundle between flit requesters and the shared LISNoC link of lisnoc_mp_simple_arb.
// slave: arbiter side; master: requesters plus link sink.
interface lisnoc_mp_simple_arb_if #(
  parameter int unsigned ports      = 2,
  parameter int unsigned flit_width = 34
);
  logic [ports*flit_width-1:0] in_flit;
  logic [ports-1:0]            in_valid;
  logic [ports-1:0]            in_ready;
  logic [flit_width-1:0]       out_flit;
  logic                        out_valid;
  logic                        out_ready;

  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_valid
  );

  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_valid
  );
endinterface

// File: rtl/lisnoc_mp_simple_arb.sv
// Per-packet round-robin arbiter sharing one LISNoC link among several flit sources.
// Define LISNOC_MP_SIMPLE_ARB_OUTREG_EN for a registered output stage; default is combinational bypass.
module lisnoc_mp_simple_arb #(
  parameter int unsigned noc_data_width = 32,
  parameter int unsigned noc_type_width = 2,
  parameter int unsigned ports          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  lisnoc_mp_simple_arb_if.slave       bus
);

  localparam int unsigned flit_width = noc_data_width + noc_type_width;
  localparam int unsigned sel_w      = (ports > 1) ? $clog2(ports) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [sel_w-1:0]      grant_q, grant_d;
  logic [sel_w-1:0]      last_q, last_d;

  logic [flit_width-1:0] flits_c [ports];
  logic [sel_w-1:0]      idx_c;
  logic [sel_w-1:0]      winner_c;
  logic                  any_valid_c;
  logic [sel_w-1:0]      sel_c;
  logic                  req_valid_c;
  logic [flit_width-1:0] sel_flit_c;
  logic                  eop_c;
  logic                  accept_c;
  logic                  xfer_c;
  logic [ports-1:0]      in_ready_c;

  always_comb begin
    for (int unsigned i = 0; i < ports; i++) begin
      flits_c[i] = bus.in_flit[i*flit_width +: flit_width];
    end
  end

  // Round-robin search starting just after the last served requester
  always_comb begin
    idx_c       = '0;
    winner_c    = last_q;
    any_valid_c = 1'b0;
    for (int unsigned i = 1; i <= ports; i++) begin
      idx_c = sel_w'((32'(last_q) + i) % ports);
      if (!any_valid_c && bus.in_valid[idx_c]) begin
        any_valid_c = 1'b1;
        winner_c    = idx_c;
      end
    end
  end

  assign sel_c       = (state_q == LOCKED) ? grant_q : winner_c;
  assign req_valid_c = (state_q == LOCKED) ? bus.in_valid[sel_c] : any_valid_c;
  assign sel_flit_c  = flits_c[sel_c];
  assign eop_c       = sel_flit_c[flit_width-1];
  assign xfer_c      = rst & req_valid_c & accept_c;

  always_comb begin
    in_ready_c = '0;
    if (rst && ((state_q == LOCKED) || any_valid_c)) begin
      in_ready_c[sel_c] = accept_c;
    end
  end

  assign bus.in_ready = in_ready_c;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          if (eop_c) begin
            last_d = winner_c;
          end else begin
            state_d = LOCKED;
            grant_d = winner_c;
          end
        end
      end
      LOCKED: begin
        if (xfer_c && eop_c) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= sel_w'(ports - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef LISNOC_MP_SIMPLE_ARB_OUTREG_EN
  logic                  out_valid_q, out_valid_d;
  logic [flit_width-1:0] out_flit_q, out_flit_d;

  // Output slot refills whenever it is empty or draining this cycle
  assign accept_c = !out_valid_q | bus.out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    if (accept_c) begin
      out_valid_d = req_valid_c;
      if (req_valid_c) begin
        out_flit_d = sel_flit_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_flit  = out_flit_q;
`else
  assign accept_c      = bus.out_ready;
  assign bus.out_valid = rst & req_valid_c;
  assign bus.out_flit  = sel_flit_c;
`endif

endmodule

// File: tb/tb_lisnoc_mp_simple_arb.sv
// Scoreboard bench for lisnoc_mp_simple_arb: per-port flit sources, expected link order queued at load time.
module tb_lisnoc_mp_simple_arb;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 2;
  localparam int unsigned NP = 4;
  localparam int unsigned FW = DW + TW;

  localparam logic [1:0] T_HDR  = 2'b01;
  localparam logic [1:0] T_PAY  = 2'b00;
  localparam logic [1:0] T_LAST = 2'b10;
  localparam logic [1:0] T_SGL  = 2'b11;

  typedef logic [FW-1:0] flit_t;

  logic clk;
  logic rst;

  lisnoc_mp_simple_arb_if #(.ports(NP), .flit_width(FW)) bus ();

  lisnoc_mp_simple_arb #(
    .noc_data_width(DW),
    .noc_type_width(TW),
    .ports(NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  flit_t       src_q [NP][$];
  flit_t       exp_q [$];
  logic        ready_pat [$];
  logic [NP-1:0] fired;
  logic        rst_drv;
  logic        held_vld;
  flit_t       held_flit;
  logic        lock_watch;
  logic        lock_seen_after;
  int          n_chk;
  int          n_pass;
  int          cyc;
  int          out_cnt;
  int          first_out;
  int          last_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic flit_t mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One bench cycle: drive at negedge, sample just before the next posedge
  task automatic step();
    logic [NP*FW-1:0] fl;
    logic [NP-1:0]    vl;
    @(negedge clk);
    rst = rst_drv;
    for (int i = 0; i < NP; i++) begin
      if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    fl = '0;
    vl = '0;
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0) begin
        vl[i]          = 1'b1;
        fl[i*FW +: FW] = src_q[i][0];
      end
    end
    bus.in_flit   = fl;
    bus.in_valid  = vl;
    bus.out_ready = (ready_pat.size() > 0) ? ready_pat.pop_front() : 1'b1;
    #4;
    fired = bus.in_valid & bus.in_ready;
    check("ready_onehot", 64'($countones(bus.in_ready) <= 1), 64'd1);
    if (lock_watch) begin
      if (src_q[0].size() > 0) begin
        check("lock_ready1", 64'(bus.in_ready[1]), 64'd0);
      end else if (!lock_seen_after) begin
        check("ready1_after_last", 64'(bus.in_ready[1]), 64'd1);
        lock_seen_after = 1'b1;
      end
    end
    if (bus.out_valid && held_vld) check("stall_stable", 64'(bus.out_flit), 64'(held_flit));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
      else check("out_flit", 64'(bus.out_flit), 64'(exp_q.pop_front()));
      if (out_cnt == 0) first_out = cyc;
      last_out = cyc;
      out_cnt++;
    end
    held_vld  = bus.out_valid && !bus.out_ready;
    held_flit = bus.out_flit;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    step();
    step();
  endtask

  task automatic reset_cycle();
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; out_cnt = 0; first_out = 0; last_out = 0;
    rst = 1'b0; rst_drv = 1'b0; fired = '0; held_vld = 1'b0; held_flit = '0;
    lock_watch = 1'b0; lock_seen_after = 1'b0;
    bus.in_valid = '0; bus.in_flit = '0; bus.out_ready = 1'b1;

    // Reset held with requesters valid, then port0 before port1
    src_q[0].push_back(mk(T_SGL, 32'h10));
    src_q[1].push_back(mk(T_SGL, 32'h11));
    repeat (3) reset_cycle();
    exp_q.push_back(mk(T_SGL, 32'h10));
    exp_q.push_back(mk(T_SGL, 32'h11));
    rst_drv = 1'b1;
    drain(20);

    // Packet lock: port1 must wait for port0's LAST
    src_q[0].push_back(mk(T_HDR,  32'hA0));
    src_q[0].push_back(mk(T_PAY,  32'hA1));
    src_q[0].push_back(mk(T_LAST, 32'hA2));
    src_q[1].push_back(mk(T_SGL,  32'hB0));
    exp_q.push_back(mk(T_HDR,  32'hA0));
    exp_q.push_back(mk(T_PAY,  32'hA1));
    exp_q.push_back(mk(T_LAST, 32'hA2));
    exp_q.push_back(mk(T_SGL,  32'hB0));
    lock_watch = 1'b1;
    drain(30);
    lock_watch = 1'b0;

    // Backpressure during a 3-flit packet
    src_q[2].push_back(mk(T_HDR,  32'hC0));
    src_q[2].push_back(mk(T_PAY,  32'hC1));
    src_q[2].push_back(mk(T_LAST, 32'hC2));
    exp_q.push_back(mk(T_HDR,  32'hC0));
    exp_q.push_back(mk(T_PAY,  32'hC1));
    exp_q.push_back(mk(T_LAST, 32'hC2));
    ready_pat.push_back(1'b1);
    ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b1);
    drain(30);

    // Reset after port1's HEADER abandons the packet; port0 wins afterwards
    src_q[1].push_back(mk(T_HDR, 32'hD0));
    exp_q.push_back(mk(T_HDR, 32'hD0));
    drain(20);
    src_q[1].push_back(mk(T_PAY,  32'hD1));
    src_q[1].push_back(mk(T_LAST, 32'hD2));
    src_q[0].push_back(mk(T_SGL,  32'hE0));
    rst_drv = 1'b0;
    repeat (2) reset_cycle();
    exp_q.push_back(mk(T_SGL,  32'hE0));
    exp_q.push_back(mk(T_PAY,  32'hD1));
    exp_q.push_back(mk(T_LAST, 32'hD2));
    rst_drv = 1'b1;
    drain(30);

    // Fairness and sustained throughput with all ports streaming 2-flit packets
    rst_drv = 1'b0;
    reset_cycle();
    rst_drv = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < NP; p++) begin
        src_q[p].push_back(mk(T_HDR,  32'(p*16 + k*2)));
        src_q[p].push_back(mk(T_LAST, 32'(p*16 + k*2 + 1)));
        exp_q.push_back(mk(T_HDR,  32'(p*16 + k*2)));
        exp_q.push_back(mk(T_LAST, 32'(p*16 + k*2 + 1)));
      end
    end
    out_cnt = 0;
    drain(80);
    check("fair_out_count", 64'(out_cnt), 64'd16);
    check("throughput_span", 64'(last_out - first_out + 1), 64'd16);

    step();
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
